// File: rtl/bid_arbiter.sv
// bid_arbiter: three-bidder (X/Y/Z) round-robin arbiter feeding a single
// engine. Each bidder owns one pending slot. Grants are issued one at a time
// through IDLE -> ISSUE -> WAIT -> DONE, and WAIT is bounded by a watchdog.
// Optional feature macro: BID_ARB_MASK_EN. When it is defined, the design adds
// the mask_load/mask_in ports and a 3-bit bidder mask.
module bid_arbiter #(
    parameter int unsigned AMT_W = 16,
    parameter int unsigned WDOG  = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             X_bid,
    input  logic             Y_bid,
    input  logic             Z_bid,
    input  logic [AMT_W-1:0] X_bidAmt,
    input  logic [AMT_W-1:0] Y_bidAmt,
    input  logic [AMT_W-1:0] Z_bidAmt,
    input  logic             X_retract,
    input  logic             Y_retract,
    input  logic             Z_retract,
    input  logic             roundActive,
`ifdef BID_ARB_MASK_EN
    input  logic             mask_load,
    input  logic [2:0]       mask_in,
`endif
    output logic             X_ack,
    output logic             Y_ack,
    output logic             Z_ack,
    output logic [1:0]       X_err,
    output logic [1:0]       Y_err,
    output logic [1:0]       Z_err,
    output logic             eng_valid,
    output logic [1:0]       eng_id,
    output logic [AMT_W-1:0] eng_amt,
    output logic             eng_retract,
    input  logic             eng_ready,
    input  logic             eng_done,
    input  logic [1:0]       eng_err
);

    localparam int unsigned CNT_W = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              w_bid, w_ret, w_req, w_rej, w_cap, w_mask;
    logic [2:0][AMT_W-1:0]   w_amt;
    logic [2:0]              r_pend, r_ret;
    logic [2:0][AMT_W-1:0]   r_amt;
    logic [1:0]              r_ptr;
    logic                    w_sel_vld;
    logic [1:0]              w_sel_id;
    logic                    w_grant, w_hs, w_wdog;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_res_err;
    logic                    r_eng_valid, r_eng_ret;
    logic [1:0]              r_eng_id;
    logic [AMT_W-1:0]        r_eng_amt;
    logic [2:0]              r_ack, w_ack_nxt, r_hold_v, w_hold_v_nxt, w_flush;
    logic [2:0][1:0]         r_err, w_err_nxt, r_hold_err, w_hold_err_nxt, w_rej_err;

    // Next round-robin index, wrapping Z back to X.
    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign w_bid = {Z_bid, Y_bid, X_bid};
    assign w_ret = {Z_retract, Y_retract, X_retract};
    assign w_amt = {Z_bidAmt, Y_bidAmt, X_bidAmt};
    assign w_req = w_bid | w_ret;
    assign w_rej = w_req & (w_mask | {3{~roundActive}});
    assign w_cap = w_req & ~w_rej;

`ifdef BID_ARB_MASK_EN
    logic [2:0] r_mask;

    // Bidder mask register; a set bit refuses that bidder's requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= 3'b000;
        end else if (mask_load) begin
            r_mask <= mask_in;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = 3'b000;
`endif

    // Rejection status: a masked bidder takes precedence over a closed round.
    always_comb begin
        w_rej_err = '0;
        for (int i = 0; i < 3; i++) begin
            w_rej_err[i] = w_mask[i] ? 2'b11 : 2'b10;
        end
    end

    // Round-robin pick: the first pending slot at or after r_ptr.
    always_comb begin
        logic [1:0] w_idx;
        w_sel_vld = 1'b0;
        w_sel_id  = 2'd0;
        w_idx     = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!w_sel_vld && r_pend[w_idx]) begin
                w_sel_vld = 1'b1;
                w_sel_id  = w_idx;
            end
            w_idx = wrap_inc(w_idx);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and the single-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_hs        = 1'b0;
        w_wdog      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (roundActive && w_sel_vld) begin
                    w_state_nxt = S_ISSUE;
                    w_grant     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (eng_ready) begin
                    w_state_nxt = S_WAIT;
                    w_hs        = 1'b1;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_wdog      = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Slots: a capture always wins, so the granted bidder can queue a fresh entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_ret  <= '0;
            r_amt  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_cap[i]) begin
                    r_pend[i] <= 1'b1;
                    r_ret[i]  <= w_ret[i];
                    r_amt[i]  <= w_ret[i] ? '0 : w_amt[i];
                end else if ((w_grant && (w_sel_id == 2'(i))) || w_flush[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Engine request registers; the grant's content moves out of the slot here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eng_valid <= 1'b0;
            r_eng_id    <= 2'd0;
            r_eng_amt   <= '0;
            r_eng_ret   <= 1'b0;
        end else if (w_grant) begin
            r_eng_valid <= 1'b1;
            r_eng_id    <= w_sel_id;
            r_eng_amt   <= r_amt[w_sel_id];
            r_eng_ret   <= r_ret[w_sel_id];
        end else if (w_hs) begin
            r_eng_valid <= 1'b0;
        end
    end

    // Watchdog counter, result status and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_res_err <= 2'b00;
            r_ptr     <= 2'd0;
        end else begin
            r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == S_WAIT && eng_done) begin
                r_res_err <= eng_err;
            end else if (w_wdog) begin
                r_res_err <= 2'b01;
            end
            if (r_state == S_DONE) begin
                r_ptr <= wrap_inc(r_eng_id);
            end
        end
    end

    // Ack arbitration per bidder: DONE, held reject, new reject, then flush.
    always_comb begin
        w_ack_nxt      = '0;
        w_flush        = '0;
        w_err_nxt      = r_err;
        w_hold_v_nxt   = r_hold_v;
        w_hold_err_nxt = r_hold_err;
        for (int i = 0; i < 3; i++) begin
            if (r_state == S_DONE && r_eng_id == 2'(i)) begin
                w_ack_nxt[i] = 1'b1;
                w_err_nxt[i] = r_res_err;
                if (w_rej[i]) begin
                    w_hold_v_nxt[i]   = 1'b1;
                    w_hold_err_nxt[i] = w_rej_err[i];
                end
            end else if (r_hold_v[i]) begin
                w_ack_nxt[i]      = 1'b1;
                w_err_nxt[i]      = r_hold_err[i];
                w_hold_v_nxt[i]   = w_rej[i];
                w_hold_err_nxt[i] = w_rej_err[i];
            end else if (w_rej[i]) begin
                w_ack_nxt[i] = 1'b1;
                w_err_nxt[i] = w_rej_err[i];
            end else if (!roundActive && r_pend[i]) begin
                w_ack_nxt[i] = 1'b1;
                w_err_nxt[i] = 2'b10;
                w_flush[i]   = 1'b1;
            end
        end
    end

    // Registered ack/err outputs and the deferred-reject holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack      <= '0;
            r_err      <= '0;
            r_hold_v   <= '0;
            r_hold_err <= '0;
        end else begin
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_hold_v   <= w_hold_v_nxt;
            r_hold_err <= w_hold_err_nxt;
        end
    end

    assign X_ack       = r_ack[0];
    assign Y_ack       = r_ack[1];
    assign Z_ack       = r_ack[2];
    assign X_err       = r_err[0];
    assign Y_err       = r_err[1];
    assign Z_err       = r_err[2];
    assign eng_valid   = r_eng_valid;
    assign eng_id      = r_eng_id;
    assign eng_amt     = r_eng_amt;
    assign eng_retract = r_eng_ret;

endmodule

// File: tb/tb_bid_arbiter.sv
// Directed self-checking bench for bid_arbiter (AMT_W=16, WDOG=15).
// Mask checks are compiled only when BID_ARB_MASK_EN is defined.
module tb_bid_arbiter;

    localparam int unsigned AMT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             X_bid, Y_bid, Z_bid;
    logic [AMT_W-1:0] X_bidAmt, Y_bidAmt, Z_bidAmt;
    logic             X_retract, Y_retract, Z_retract;
    logic             roundActive;
    logic             X_ack, Y_ack, Z_ack;
    logic [1:0]       X_err, Y_err, Z_err;
    logic             eng_valid, eng_retract, eng_ready, eng_done;
    logic [1:0]       eng_id, eng_err;
    logic [AMT_W-1:0] eng_amt;
`ifdef BID_ARB_MASK_EN
    logic             mask_load;
    logic [2:0]       mask_in;
`endif

    logic [2:0] acks;
    logic [5:0] errs;
    assign acks = {Z_ack, Y_ack, X_ack};
    assign errs = {Z_err, Y_err, X_err};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bid_arbiter #(.AMT_W(AMT_W), .WDOG(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .X_bid(X_bid), .Y_bid(Y_bid), .Z_bid(Z_bid),
        .X_bidAmt(X_bidAmt), .Y_bidAmt(Y_bidAmt), .Z_bidAmt(Z_bidAmt),
        .X_retract(X_retract), .Y_retract(Y_retract), .Z_retract(Z_retract),
        .roundActive(roundActive),
`ifdef BID_ARB_MASK_EN
        .mask_load(mask_load), .mask_in(mask_in),
`endif
        .X_ack(X_ack), .Y_ack(Y_ack), .Z_ack(Z_ack),
        .X_err(X_err), .Y_err(Y_err), .Z_err(Z_err),
        .eng_valid(eng_valid), .eng_id(eng_id), .eng_amt(eng_amt),
        .eng_retract(eng_retract), .eng_ready(eng_ready),
        .eng_done(eng_done), .eng_err(eng_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the issue, check its payload, then check ack latency and status.
    task automatic run_grant(input logic [1:0] id, input logic [15:0] amt, input logic ret,
                             input bit chk_amt, input logic [1:0] err, input int lat,
                             input string tag);
        int n;
        n = 0;
        while (eng_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(eng_valid), 32'd1);
        chk({tag, "_id"}, 32'(eng_id), 32'(id));
        if (chk_amt) chk({tag, "_amt"}, 32'(eng_amt), 32'(amt));
        chk({tag, "_ret"}, 32'(eng_retract), 32'(ret));
        n = 0;
        while (acks[id] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_err"}, 32'(errs[int'(id)*2 +: 2]), 32'(err));
    endtask

    // Run some cycles and require no ack for one bidder and no engine issue.
    task automatic quiet(input int cycles, input int who, input string tag);
        int n_ack;
        int n_vld;
        n_ack = 0;
        n_vld = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (acks[who] !== 1'b0) n_ack++;
            if (eng_valid !== 1'b0) n_vld++;
        end
        chk({tag, "_no_ack"}, 32'(n_ack), 32'd0);
        chk({tag, "_no_issue"}, 32'(n_vld), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        {X_bid, Y_bid, Z_bid, X_retract, Y_retract, Z_retract} = '0;
        X_bidAmt = '0; Y_bidAmt = '0; Z_bidAmt = '0;
        roundActive = 1'b0; eng_ready = 1'b0; eng_done = 1'b0; eng_err = 2'b00;
`ifdef BID_ARB_MASK_EN
        mask_load = 1'b0; mask_in = 3'b000;
`endif
        repeat (3) tick();
        chk("rst_valid", 32'(eng_valid), 32'd0);
        chk("rst_id", 32'(eng_id), 32'd0);
        chk("rst_amt", 32'(eng_amt), 32'd0);
        chk("rst_ret", 32'(eng_retract), 32'd0);
        chk("rst_acks", 32'(acks), 32'd0);
        chk("rst_errs", 32'(errs), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic X bid with an immediate engine: ack 3 cycles after issue.
        roundActive = 1'b1; eng_ready = 1'b1; eng_done = 1'b1; eng_err = 2'b00;
        X_bid = 1'b1; X_bidAmt = 16'h0010;
        tick();
        X_bid = 1'b0;
        chk("x_basic_no_issue_yet", 32'(eng_valid), 32'd0);
        run_grant(2'd0, 16'h0010, 1'b0, 1'b1, 2'b00, 3, "x_basic");

        // Z bid and retract together: only the retract is stored.
        Z_bid = 1'b1; Z_retract = 1'b1; Z_bidAmt = 16'h1234;
        tick();
        Z_bid = 1'b0; Z_retract = 1'b0;
        run_grant(2'd2, 16'h0000, 1'b1, 1'b0, 2'b00, 3, "z_retract");

        // The pointer is back at X: simultaneous X,Y,Z are served X,Y,Z.
        X_bid = 1'b1; Y_bid = 1'b1; Z_bid = 1'b1;
        X_bidAmt = 16'h0001; Y_bidAmt = 16'h0002; Z_bidAmt = 16'h0003;
        tick();
        {X_bid, Y_bid, Z_bid} = '0;
        run_grant(2'd0, 16'h0001, 1'b0, 1'b1, 2'b00, 3, "rr1_x");
        run_grant(2'd1, 16'h0002, 1'b0, 1'b1, 2'b00, 3, "rr1_y");
        run_grant(2'd2, 16'h0003, 1'b0, 1'b1, 2'b00, 3, "rr1_z");
        X_bid = 1'b1; Y_bid = 1'b1; X_bidAmt = 16'h0004; Y_bidAmt = 16'h0005;
        tick();
        {X_bid, Y_bid} = '0;
        run_grant(2'd0, 16'h0004, 1'b0, 1'b1, 2'b00, 3, "rr2_x");
        run_grant(2'd1, 16'h0005, 1'b0, 1'b1, 2'b00, 3, "rr2_y");

        // Y rebids while the engine is stalled: the latest amount wins.
        eng_ready = 1'b0;
        X_bid = 1'b1; X_bidAmt = 16'h0AAA;
        tick();
        X_bid = 1'b0;
        tick();
        chk("stall_valid", 32'(eng_valid), 32'd1);
        Y_bid = 1'b1; Y_bidAmt = 16'h0005;
        tick();
        Y_bidAmt = 16'hFFFF;
        tick();
        Y_bid = 1'b0;
        tick();
        chk("stall_hold_valid", 32'(eng_valid), 32'd1);
        chk("stall_hold_id", 32'(eng_id), 32'd0);
        chk("stall_hold_amt", 32'(eng_amt), 32'h0AAA);
        eng_err = 2'b11; eng_ready = 1'b1;
        run_grant(2'd0, 16'h0AAA, 1'b0, 1'b1, 2'b11, 3, "stall_x");
        run_grant(2'd1, 16'hFFFF, 1'b0, 1'b1, 2'b11, 3, "latest_y");
        quiet(8, 1, "latest_y_single");
        eng_err = 2'b00;

        // Engine never completes: watchdog aborts after 15 WAIT cycles.
        eng_done = 1'b0;
        X_bid = 1'b1; X_bidAmt = 16'h0077;
        tick();
        X_bid = 1'b0;
        run_grant(2'd0, 16'h0077, 1'b0, 1'b1, 2'b01, 17, "wdog");
        eng_done = 1'b1;

        // Round closes with X in flight: Y,Z flushed, X completes normally.
        eng_ready = 1'b0;
        X_bid = 1'b1; X_bidAmt = 16'h0101;
        tick();
        X_bid = 1'b0;
        tick();
        chk("flush_x_issued", 32'(eng_valid), 32'd1);
        Y_bid = 1'b1; Z_bid = 1'b1; Y_bidAmt = 16'h0002; Z_bidAmt = 16'h0003;
        tick();
        {Y_bid, Z_bid} = '0;
        roundActive = 1'b0;
        tick();
        chk("flush_acks", 32'(acks), 32'b110);
        chk("flush_y_err", 32'(Y_err), 32'b10);
        chk("flush_z_err", 32'(Z_err), 32'b10);
        eng_ready = 1'b1;
        run_grant(2'd0, 16'h0101, 1'b0, 1'b1, 2'b00, 3, "flush_x");

        // Bid while the round is closed: rejected next cycle, never issued.
        X_bid = 1'b1; X_bidAmt = 16'h0010;
        tick();
        X_bid = 1'b0;
        chk("closed_x_ack", 32'(X_ack), 32'd1);
        chk("closed_x_err", 32'(X_err), 32'b10);
        quiet(6, 0, "closed_x");

        // A DONE ack for X and a rejection ack for Y in the same cycle.
        roundActive = 1'b1;
        X_bid = 1'b1; X_bidAmt = 16'h0042;
        tick();
        X_bid = 1'b0;
        tick();
        chk("dual_x_issued", 32'(eng_valid), 32'd1);
        tick();
        tick();
        roundActive = 1'b0; Y_bid = 1'b1;
        tick();
        Y_bid = 1'b0; roundActive = 1'b1;
        chk("dual_acks", 32'({Y_ack, X_ack}), 32'b11);
        chk("dual_x_err", 32'(X_err), 32'b00);
        chk("dual_y_err", 32'(Y_err), 32'b10);

`ifdef BID_ARB_MASK_EN
        // A masked bidder is refused with status 2'b11 and never issued.
        mask_load = 1'b1; mask_in = 3'b010;
        tick();
        mask_load = 1'b0;
        Y_bid = 1'b1; Y_bidAmt = 16'h0033;
        tick();
        Y_bid = 1'b0;
        chk("mask_y_ack", 32'(Y_ack), 32'd1);
        chk("mask_y_err", 32'(Y_err), 32'b11);
        tick();
        chk("mask_y_no_issue", 32'(eng_valid), 32'd0);
`endif

        // Reset in the middle of a transaction drops it without an ack.
        tick();
        eng_ready = 1'b0;
        X_bid = 1'b1; X_bidAmt = 16'h0005;
        tick();
        X_bid = 1'b0;
        tick();
        chk("midrst_issued", 32'(eng_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(eng_valid), 32'd0);
        chk("midrst_amt", 32'(eng_amt), 32'd0);
        chk("midrst_errs", 32'(errs), 32'd0);
        tick();
        reset_n = 1'b1;
        eng_ready = 1'b1;
        quiet(6, 0, "midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
